// File: rtl/arp_table_ctrl_if.sv
// rtl/arp_table_ctrl_if.sv - lookup, response and software-op signal bundle for arp_table_ctrl
interface arp_table_ctrl_if #(
    parameter int IDX_W = 5
);
    logic             lkup_valid;
    logic             lkup_ready;
    logic [31:0]      lkup_ip;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_hit;
    logic [IDX_W-1:0] rsp_index;
    logic [47:0]      rsp_mac;
    logic             sw_req;
    logic             sw_we;
    logic [IDX_W-1:0] sw_index;
    logic             sw_wvld;
    logic [31:0]      sw_wip;
    logic [47:0]      sw_wmac;
    logic             sw_ack;
    logic             sw_err;
    logic             sw_rvld;
    logic [31:0]      sw_rip;
    logic [47:0]      sw_rmac;
    logic [31:0]      hit_cnt;
    logic [31:0]      miss_cnt;

    modport master (
        output lkup_valid, lkup_ip, rsp_ready,
        output sw_req, sw_we, sw_index, sw_wvld, sw_wip, sw_wmac,
        input  lkup_ready, rsp_valid, rsp_hit, rsp_index, rsp_mac,
        input  sw_ack, sw_err, sw_rvld, sw_rip, sw_rmac, hit_cnt, miss_cnt
    );

    modport slave (
        input  lkup_valid, lkup_ip, rsp_ready,
        input  sw_req, sw_we, sw_index, sw_wvld, sw_wip, sw_wmac,
        output lkup_ready, rsp_valid, rsp_hit, rsp_index, rsp_mac,
        output sw_ack, sw_err, sw_rvld, sw_rip, sw_rmac, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/arp_table_ctrl.sv
// rtl/arp_table_ctrl.sv - ARP table with chunked lookup scan and arbitrated software access
// Optional hit/miss statistics counters are built when ARP_STATS_EN is defined.
module arp_table_ctrl #(
    parameter int NUM_ENTRIES       = 32,
    parameter int IDX_W             = 5,
    parameter int ENTRIES_PER_CYCLE = 4
) (
    input logic             AXI_ACLK,
    input logic             AXI_RESET,
    arp_table_ctrl_if.slave bus
);
    localparam int AW     = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int NCHUNK = NUM_ENTRIES / ENTRIES_PER_CYCLE;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, SEARCH, RESP, SW_OP} state_t;

    state_t                 state_q;
    logic [NUM_ENTRIES-1:0] vld_q;
    logic [31:0]            ip_q  [NUM_ENTRIES];
    logic [47:0]            mac_q [NUM_ENTRIES];
    logic [31:0]            key_q;
    logic [CW-1:0]          chunk_q;
    logic                   prio_sw_q;
    logic                   rsp_valid_q;
    logic                   rsp_hit_q;
    logic [IDX_W-1:0]       rsp_index_q;
    logic [47:0]            rsp_mac_q;
    logic                   sw_ack_q;
    logic                   sw_err_q;
    logic                   sw_rvld_q;
    logic [31:0]            sw_rip_q;
    logic [47:0]            sw_rmac_q;

    logic          idle_ok;
    logic          sw_pend;
    logic          sw_grant;
    logic          lk_grant;
    logic          sw_in_range;
    logic [AW-1:0] sw_idx;

    // A request still high during its own ack cycle is the one just served, not a new one.
    assign idle_ok     = (state_q == IDLE) && !AXI_RESET;
    assign sw_pend     = bus.sw_req && !sw_ack_q;
    assign sw_grant    = idle_ok && sw_pend && (!bus.lkup_valid || prio_sw_q);
    assign lk_grant    = idle_ok && bus.lkup_valid && !sw_grant;
    assign sw_in_range = 32'(bus.sw_index) < 32'(NUM_ENTRIES);
    assign sw_idx      = bus.sw_index[AW-1:0];

    assign bus.lkup_ready = idle_ok && !sw_grant;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_hit    = rsp_hit_q;
    assign bus.rsp_index  = rsp_index_q;
    assign bus.rsp_mac    = rsp_mac_q;
    assign bus.sw_ack     = sw_ack_q;
    assign bus.sw_err     = sw_err_q;
    assign bus.sw_rvld    = sw_rvld_q;
    assign bus.sw_rip     = sw_rip_q;
    assign bus.sw_rmac    = sw_rmac_q;

    logic          match_found;
    logic [AW-1:0] match_idx;
    logic [AW-1:0] ent;

    // Walk the chunk from the top down so the lowest matching index is the one kept.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        ent         = '0;
        for (int e = ENTRIES_PER_CYCLE - 1; e >= 0; e--) begin
            ent = AW'(int'(chunk_q) * ENTRIES_PER_CYCLE + e);
            if (vld_q[ent] && (ip_q[ent] == key_q)) begin
                match_found = 1'b1;
                match_idx   = ent;
            end
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            state_q     <= IDLE;
            vld_q       <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ip_q[i]  <= '0;
                mac_q[i] <= '0;
            end
            key_q       <= '0;
            chunk_q     <= '0;
            prio_sw_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_index_q <= '0;
            rsp_mac_q   <= '0;
            sw_ack_q    <= 1'b0;
            sw_err_q    <= 1'b0;
            sw_rvld_q   <= 1'b0;
            sw_rip_q    <= '0;
            sw_rmac_q   <= '0;
        end else begin
            sw_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sw_grant) begin
                        state_q <= SW_OP;
                    end else if (lk_grant) begin
                        key_q   <= bus.lkup_ip;
                        chunk_q <= '0;
                        state_q <= SEARCH;
                    end
                    // Round-robin only moves when both sides actually contend.
                    if (idle_ok && bus.lkup_valid && sw_pend) begin
                        prio_sw_q <= !sw_grant;
                    end
                end
                SEARCH: begin
                    if (match_found) begin
                        rsp_hit_q   <= 1'b1;
                        rsp_index_q <= IDX_W'(match_idx);
                        rsp_mac_q   <= mac_q[match_idx];
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (chunk_q == LAST_CHUNK) begin
                        rsp_hit_q   <= 1'b0;
                        rsp_index_q <= '0;
                        rsp_mac_q   <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        chunk_q <= chunk_q + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                SW_OP: begin
                    sw_ack_q <= 1'b1;
                    sw_err_q <= !sw_in_range;
                    if (!sw_in_range) begin
                        sw_rvld_q <= 1'b0;
                        sw_rip_q  <= '0;
                        sw_rmac_q <= '0;
                    end else if (bus.sw_we) begin
                        vld_q[sw_idx] <= bus.sw_wvld;
                        ip_q[sw_idx]  <= bus.sw_wip;
                        mac_q[sw_idx] <= bus.sw_wmac;
                    end else begin
                        sw_rvld_q <= vld_q[sw_idx];
                        sw_rip_q  <= ip_q[sw_idx];
                        sw_rmac_q <= mac_q[sw_idx];
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ARP_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == SEARCH) begin
            if (match_found) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else if (chunk_q == LAST_CHUNK) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign bus.hit_cnt  = hit_cnt_q;
    assign bus.miss_cnt = miss_cnt_q;
`else
    assign bus.hit_cnt  = '0;
    assign bus.miss_cnt = '0;
`endif
endmodule

// File: tb/tb_arp_table_ctrl.sv
// tb/tb_arp_table_ctrl.sv - directed vector bench for arp_table_ctrl
module tb_arp_table_ctrl;
    localparam int OP_WR = 0;
    localparam int OP_RD = 1;
    localparam int OP_LK = 2;
    localparam int NV    = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arp_table_ctrl_if #(.IDX_W(5)) bus  ();
    arp_table_ctrl_if #(.IDX_W(6)) bus6 ();

    arp_table_ctrl #(.NUM_ENTRIES(32), .IDX_W(5), .ENTRIES_PER_CYCLE(4)) u_dut (
        .AXI_ACLK (clk),
        .AXI_RESET(rst),
        .bus      (bus)
    );

    arp_table_ctrl #(.NUM_ENTRIES(32), .IDX_W(6), .ENTRIES_PER_CYCLE(4)) u_dut6 (
        .AXI_ACLK (clk),
        .AXI_RESET(rst),
        .bus      (bus6)
    );

    typedef struct {
        int          op;
        logic [4:0]  idx;
        logic        vld;
        logic [31:0] ip;
        logic [47:0] mac;
        logic        e_hit;
        logic [4:0]  e_idx;
        logic [47:0] e_mac;
        int          e_lat;
    } vec_t;

    vec_t vecs [NV];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_hits = 0;
    int   exp_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sw_op(input logic we, input logic [4:0] idx, input logic vld, input logic [31:0] ip,
                         input logic [47:0] mac, output logic got, output logic err, output logic rvld,
                         output logic [31:0] rip, output logic [47:0] rmac);
        @(negedge clk);
        bus.sw_we = we; bus.sw_index = idx; bus.sw_wvld = vld; bus.sw_wip = ip; bus.sw_wmac = mac;
        bus.sw_req = 1'b1;
        got = 1'b0; err = 1'b0; rvld = 1'b0; rip = '0; rmac = '0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk); #2;
            if (bus.sw_ack) begin
                got = 1'b1; err = bus.sw_err; rvld = bus.sw_rvld; rip = bus.sw_rip; rmac = bus.sw_rmac;
                break;
            end
        end
        bus.sw_req = 1'b0;
    endtask

    task automatic sw_op6(input logic we, input logic [5:0] idx, input logic [31:0] ip, input logic [47:0] mac,
                          output logic got, output logic err, output logic rvld,
                          output logic [31:0] rip, output logic [47:0] rmac);
        @(negedge clk);
        bus6.sw_we = we; bus6.sw_index = idx; bus6.sw_wvld = 1'b1; bus6.sw_wip = ip; bus6.sw_wmac = mac;
        bus6.sw_req = 1'b1;
        got = 1'b0; err = 1'b0; rvld = 1'b0; rip = '0; rmac = '0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk); #2;
            if (bus6.sw_ack) begin
                got = 1'b1; err = bus6.sw_err; rvld = bus6.sw_rvld; rip = bus6.sw_rip; rmac = bus6.sw_rmac;
                break;
            end
        end
        bus6.sw_req = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] ip, output logic hit, output logic [4:0] idx,
                          output logic [47:0] mac, output int lat);
        int n;
        @(negedge clk);
        bus.lkup_valid = 1'b1; bus.lkup_ip = ip;
        hit = 1'b0; idx = '0; mac = '0; lat = 999;
        n = 0; #2;
        while (!bus.lkup_ready && n < 50) begin
            @(negedge clk); #2; n++;
        end
        if (!bus.lkup_ready) begin
            bus.lkup_valid = 1'b0;
            return;
        end
        lat = 0;
        do begin
            @(negedge clk); #2; lat++;
            if (lat == 1) bus.lkup_valid = 1'b0;
        end while (!bus.rsp_valid && lat < 50);
        if (!bus.rsp_valid) begin
            lat = 999;
            return;
        end
        hit = bus.rsp_hit; idx = bus.rsp_index; mac = bus.rsp_mac;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    // Lookup and a software write raised in the same cycle; reports who completed first.
    task automatic race(input logic [31:0] ip, input logic [4:0] widx, input logic [47:0] wmac,
                        output logic ready0, output logic hit, output int rsp_cyc, output int ack_cyc);
        logic acc;
        @(negedge clk);
        bus.lkup_valid = 1'b1; bus.lkup_ip = ip;
        bus.sw_we = 1'b1; bus.sw_index = widx; bus.sw_wvld = 1'b1; bus.sw_wip = ip; bus.sw_wmac = wmac;
        bus.sw_req = 1'b1;
        rsp_cyc = -1; ack_cyc = -1; hit = 1'b0; ready0 = 1'b0;
        for (int c = 0; c < 80; c++) begin
            #2;
            if (c == 0) ready0 = bus.lkup_ready;
            if (bus.rsp_valid && rsp_cyc < 0) begin
                rsp_cyc = c; hit = bus.rsp_hit; bus.rsp_ready = 1'b1;
            end
            if (bus.sw_ack && ack_cyc < 0) begin
                ack_cyc = c; bus.sw_req = 1'b0;
            end
            acc = bus.lkup_valid && bus.lkup_ready;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            if (acc) bus.lkup_valid = 1'b0;
            if (rsp_cyc >= 0 && ack_cyc >= 0) break;
        end
        bus.lkup_valid = 1'b0; bus.sw_req = 1'b0;
    endtask

    initial begin
        logic        got, err, rvld, hit, ready0, stable, seen;
        logic [31:0] rip;
        logic [47:0] rmac, mac;
        logic [4:0]  idx;
        int          lat, rsp_cyc, ack_cyc, n;

        vecs[0]  = '{OP_WR, 5'd5,  1'b1, 32'h0A000002, 48'h001122334455, 1'b0, 5'd0,  48'h0, 0};
        vecs[1]  = '{OP_LK, 5'd0,  1'b0, 32'h0A000002, 48'h0, 1'b1, 5'd5,  48'h001122334455, 3};
        vecs[2]  = '{OP_LK, 5'd0,  1'b0, 32'h0A000009, 48'h0, 1'b0, 5'd0,  48'h0, 9};
        vecs[3]  = '{OP_WR, 5'd3,  1'b1, 32'h0A000003, 48'h0000000A0303, 1'b0, 5'd0, 48'h0, 0};
        vecs[4]  = '{OP_WR, 5'd20, 1'b1, 32'h0A000003, 48'h0000000A2020, 1'b0, 5'd0, 48'h0, 0};
        vecs[5]  = '{OP_LK, 5'd0,  1'b0, 32'h0A000003, 48'h0, 1'b1, 5'd3,  48'h0000000A0303, 2};
        vecs[6]  = '{OP_WR, 5'd3,  1'b0, 32'h0A000003, 48'h0000000A0303, 1'b0, 5'd0, 48'h0, 0};
        vecs[7]  = '{OP_LK, 5'd0,  1'b0, 32'h0A000003, 48'h0, 1'b1, 5'd20, 48'h0000000A2020, 7};
        vecs[8]  = '{OP_RD, 5'd5,  1'b1, 32'h0A000002, 48'h001122334455, 1'b0, 5'd0, 48'h0, 0};
        vecs[9]  = '{OP_RD, 5'd3,  1'b0, 32'h0A000003, 48'h0000000A0303, 1'b0, 5'd0, 48'h0, 0};
        vecs[10] = '{OP_LK, 5'd0,  1'b0, 32'h0A010102, 48'h0, 1'b1, 5'd9,  48'h0000000A0909, 4};
        vecs[11] = '{OP_WR, 5'd31, 1'b1, 32'hC0A80001, 48'h0000000A3131, 1'b0, 5'd0, 48'h0, 0};
        vecs[12] = '{OP_LK, 5'd0,  1'b0, 32'hC0A80001, 48'h0, 1'b1, 5'd31, 48'h0000000A3131, 9};
        vecs[13] = '{OP_RD, 5'd7,  1'b1, 32'h0A010101, 48'h0000000A0707, 1'b0, 5'd0, 48'h0, 0};

        bus.lkup_valid = 0; bus.lkup_ip = '0; bus.rsp_ready = 0; bus.sw_req = 0; bus.sw_we = 0;
        bus.sw_index = '0; bus.sw_wvld = 0; bus.sw_wip = '0; bus.sw_wmac = '0;
        bus6.lkup_valid = 0; bus6.lkup_ip = '0; bus6.rsp_ready = 0; bus6.sw_req = 0; bus6.sw_we = 0;
        bus6.sw_index = '0; bus6.sw_wvld = 0; bus6.sw_wip = '0; bus6.sw_wmac = '0;

        repeat (3) @(negedge clk);
        #2;
        check("rst_lkup_ready", bus.lkup_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_sw_ack", bus.sw_ack, 0);
        check("rst_sw_rvld_rip", {bus.sw_rvld, bus.sw_rip}, 0);
        check("rst_counters", {bus.hit_cnt, bus.miss_cnt}, 0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("idle_lkup_ready", bus.lkup_ready, 1);

        race(32'h0A010101, 5'd7, 48'h0000000A0707, ready0, hit, rsp_cyc, ack_cyc);
        exp_miss++;
        check("rr1_lkup_ready", ready0, 1);
        check("rr1_lkup_first", (rsp_cyc >= 0) && (ack_cyc > rsp_cyc), 1);
        check("rr1_miss", hit, 0);
        race(32'h0A010102, 5'd9, 48'h0000000A0909, ready0, hit, rsp_cyc, ack_cyc);
        exp_hits++;
        check("rr2_lkup_ready", ready0, 0);
        check("rr2_sw_first", (ack_cyc >= 0) && (rsp_cyc > ack_cyc), 1);
        check("rr2_hit", hit, 1);

        for (int i = 0; i < NV; i++) begin
            case (vecs[i].op)
                OP_WR: begin
                    sw_op(1'b1, vecs[i].idx, vecs[i].vld, vecs[i].ip, vecs[i].mac, got, err, rvld, rip, rmac);
                    check($sformatf("v%0d_wr_ack", i), got, 1);
                    check($sformatf("v%0d_wr_err", i), err, 0);
                end
                OP_RD: begin
                    sw_op(1'b0, vecs[i].idx, 1'b0, '0, '0, got, err, rvld, rip, rmac);
                    check($sformatf("v%0d_rd_ack", i), got, 1);
                    check($sformatf("v%0d_rd_data", i), {rvld, rip, rmac}, {vecs[i].vld, vecs[i].ip, vecs[i].mac});
                end
                default: begin
                    lookup(vecs[i].ip, hit, idx, mac, lat);
                    if (vecs[i].e_hit) exp_hits++;
                    else exp_miss++;
                    check($sformatf("v%0d_hit", i), hit, vecs[i].e_hit);
                    check($sformatf("v%0d_index", i), idx, vecs[i].e_idx);
                    check($sformatf("v%0d_mac", i), mac, vecs[i].e_mac);
                    check($sformatf("v%0d_latency", i), lat, vecs[i].e_lat);
                end
            endcase
        end

        // Response back-pressure with a write to the hit entry queued behind it.
        sw_op(1'b1, 5'd12, 1'b1, 32'h0A00000C, 48'hAABBCCDDEE0C, got, err, rvld, rip, rmac);
        @(negedge clk);
        bus.lkup_valid = 1'b1; bus.lkup_ip = 32'h0A00000C;
        n = 0; #2;
        while (!bus.lkup_ready && n < 50) begin @(negedge clk); #2; n++; end
        lat = 0;
        do begin
            @(negedge clk); #2; lat++;
            if (lat == 1) bus.lkup_valid = 1'b0;
        end while (!bus.rsp_valid && lat < 50);
        exp_hits++;
        check("hold_latency", lat, 5);
        check("hold_index", bus.rsp_index, 12);
        bus.sw_we = 1'b1; bus.sw_index = 5'd12; bus.sw_wvld = 1'b1;
        bus.sw_wip = 32'h0A00000C; bus.sw_wmac = 48'h0000000000CC;
        bus.sw_req = 1'b1;
        stable = 1'b1; seen = 1'b0;
        repeat (10) begin
            @(negedge clk); #2;
            if (!bus.rsp_valid || !bus.rsp_hit || bus.rsp_index != 5'd12 || bus.rsp_mac != 48'hAABBCCDDEE0C)
                stable = 1'b0;
            if (bus.sw_ack) seen = 1'b1;
        end
        check("hold_rsp_stable", stable, 1);
        check("hold_no_early_ack", seen, 0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #2;
        check("hold_rsp_cleared", bus.rsp_valid, 0);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.sw_ack) begin got = 1'b1; err = bus.sw_err; break; end
            @(negedge clk); #2;
        end
        bus.sw_req = 1'b0;
        check("hold_ack_after_rsp", got, 1);
        check("hold_ack_err", err, 0);
        sw_op(1'b0, 5'd12, 1'b0, '0, '0, got, err, rvld, rip, rmac);
        check("hold_write_landed", rmac, 48'h0000000000CC);

`ifdef ARP_STATS_EN
        check("hit_cnt", bus.hit_cnt, 32'(exp_hits));
        check("miss_cnt", bus.miss_cnt, 32'(exp_miss));
`else
        check("hit_cnt", bus.hit_cnt, 0);
        check("miss_cnt", bus.miss_cnt, 0);
`endif

        sw_op6(1'b1, 6'd8, 32'h0A000808, 48'h000000000808, got, err, rvld, rip, rmac);
        sw_op6(1'b0, 6'd8, '0, '0, got, err, rvld, rip, rmac);
        check("oor_pre_read", {err, rvld, rip}, {1'b0, 1'b1, 32'h0A000808});
        sw_op6(1'b1, 6'd40, 32'hDEADBEEF, 48'hDEADBEEFDEAD, got, err, rvld, rip, rmac);
        check("oor_wr_ack", got, 1);
        check("oor_wr_err", err, 1);
        sw_op6(1'b0, 6'd8, '0, '0, got, err, rvld, rip, rmac);
        check("oor_table_unchanged", {err, rvld, rip, rmac}, {1'b0, 1'b1, 32'h0A000808, 48'h000000000808});
        sw_op6(1'b0, 6'd40, '0, '0, got, err, rvld, rip, rmac);
        check("oor_rd_err", err, 1);
        check("oor_rd_zero", {rvld, rip, rmac}, 0);

        // Reset lands while a miss scan is two chunks in.
        @(negedge clk);
        bus.lkup_valid = 1'b1; bus.lkup_ip = 32'h0A0000FE;
        n = 0; #2;
        while (!bus.lkup_ready && n < 50) begin @(negedge clk); #2; n++; end
        @(negedge clk);
        bus.lkup_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk); #2;
            if (bus.rsp_valid || bus.sw_ack) seen = 1'b1;
        end
        check("rst_scan_no_rsp", seen, 0);
        check("rst_back_idle", bus.lkup_ready, 1);
        check("rst_counters_clear", {bus.hit_cnt, bus.miss_cnt}, 0);
        sw_op(1'b0, 5'd5, 1'b0, '0, '0, got, err, rvld, rip, rmac);
        check("rst_table_cleared", rvld, 0);
        lookup(32'h0A000002, hit, idx, mac, lat);
        check("rst_lookup_miss", {hit, idx, mac}, 0);
        check("rst_lookup_latency", lat, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
